// File: rtl/rv_dbus_axil.sv
// rv_dbus_axil -- data-side bridge from the rv32 core data port to AXI4-Lite.
//
// Core accesses whose address decodes into the external window
// ((d_adr & EXT_MASK) == EXT_BASE) become one AXI4-Lite transaction each,
// stalling the core with d_rdy low until the response arrives. Every other
// access completes at once with d_dr = 0, so the core's OR of d_dr with its
// internal read data (mtime/mtimecmp) is unaffected. Bus errors and
// transaction timeouts are recorded in a sticky error register.
//
// Ports:
//   clk, xreset          clock, asynchronous active-low reset
//   d_adr/d_re/d_we/d_dw core request (d_we nonzero = write, byte lanes)
//   d_dr, d_rdy          read data / ready (stall when low) to the core
//   m_aw*/m_w*/m_b*      AXI4-Lite write address, data, response channels
//   m_ar*/m_r*           AXI4-Lite read address, data channels
//   err_clr              clears err and err_adr
//   err, err_adr         sticky error flag, address of first failing access
module rv_dbus_axil #(
  parameter logic [31:0] EXT_BASE = 32'h8000_0000,
  parameter logic [31:0] EXT_MASK = 32'hF000_0000,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic [31:0] d_adr,
  input  logic        d_re,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_dw,
  output logic [31:0] d_dr,
  output logic        d_rdy,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic        err_clr,
  output logic        err,
  output logic [31:0] err_adr
);

  localparam int unsigned   CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]   TO_DATA  = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   dr_q, dr_d;
  logic          err_q, err_d;
  logic [31:0]   err_adr_q, err_adr_d;

  logic busy;
  logic timeout;
  logic accept;
  logic in_win;
  logic err_ev;
  logic aw_now;
  logic w_now;

  // Ready/data to the core depend only on state, never on the slave.
  assign d_rdy = (state_q == S_IDLE) || (state_q == S_DONE);
  assign d_dr  = (state_q == S_DONE) ? dr_q : '0;

  assign busy    = (state_q == S_WADDR) || (state_q == S_WRESP) ||
                   (state_q == S_RADDR) || (state_q == S_RDATA);
  // In the final counted cycle every valid/ready is withheld, so no handshake
  // can race with the abort.
  assign timeout = busy && (cnt_q == CNT_LAST);

  assign accept = d_rdy && (d_re || (d_we != 4'b0000));
  assign in_win = (d_adr & EXT_MASK) == EXT_BASE;

  assign m_awaddr  = adr_q;
  assign m_araddr  = adr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_awvalid = (state_q == S_WADDR) && !aw_done_q && !timeout;
  assign m_wvalid  = (state_q == S_WADDR) && !w_done_q  && !timeout;
  assign m_bready  = (state_q == S_WRESP) && !timeout;
  assign m_arvalid = (state_q == S_RADDR) && !timeout;
  assign m_rready  = (state_q == S_RDATA) && !timeout;

  assign err     = err_q;
  assign err_adr = err_adr_q;

  assign aw_now = aw_done_q || (m_awvalid && m_awready);
  assign w_now  = w_done_q  || (m_wvalid  && m_wready);

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    dr_d      = dr_q;
    err_d     = err_q;
    err_adr_d = err_adr_q;
    err_ev    = 1'b0;

    if (busy) begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept && in_win) begin
          adr_d     = d_adr;
          wdata_d   = d_dw;
          wstrb_d   = d_we;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = '0;
          // A write wins when both d_re and d_we are presented.
          state_d   = (d_we != 4'b0000) ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        if (timeout) begin
          state_d = S_DONE;
          dr_d    = '0;
          err_ev  = 1'b1;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
          if (aw_now && w_now) begin
            state_d = S_WRESP;
          end
        end
      end
      S_WRESP: begin
        if (timeout) begin
          state_d = S_DONE;
          dr_d    = '0;
          err_ev  = 1'b1;
        end else if (m_bvalid) begin
          state_d = S_DONE;
          dr_d    = '0;
          err_ev  = (m_bresp != 2'b00);
        end
      end
      S_RADDR: begin
        if (timeout) begin
          state_d = S_DONE;
          dr_d    = TO_DATA;
          err_ev  = 1'b1;
        end else if (m_arready) begin
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (timeout) begin
          state_d = S_DONE;
          dr_d    = TO_DATA;
          err_ev  = 1'b1;
        end else if (m_rvalid) begin
          state_d = S_DONE;
          dr_d    = m_rdata;
          err_ev  = (m_rresp != 2'b00);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new error takes precedence over a simultaneous clear; the address
    // of an earlier, still-flagged error is kept.
    if (err_ev) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_adr_d = adr_q;
      end
    end else if (err_clr) begin
      err_d     = 1'b0;
      err_adr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_q   <= S_IDLE;
      adr_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      dr_q      <= '0;
      err_q     <= 1'b0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      dr_q      <= dr_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
    end
  end

endmodule

// File: tb/tb_rv_dbus_axil.sv
// Directed bench for rv_dbus_axil. Each stimulus step states what the
// outputs must be in the current cycle; a single compare process checks
// them on every falling edge. Error state is tracked by a small model.
module tb_rv_dbus_axil;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        xreset;
  logic [31:0] d_adr;
  logic        d_re;
  logic [3:0]  d_we;
  logic [31:0] d_dw;
  logic [31:0] d_dr;
  logic        d_rdy;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic        err_clr;
  logic        err;
  logic [31:0] err_adr;

  always #5 clk = ~clk;

  rv_dbus_axil #(
    .EXT_BASE(32'h8000_0000),
    .EXT_MASK(32'hF000_0000),
    .TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .xreset   (xreset),
    .d_adr    (d_adr),
    .d_re     (d_re),
    .d_we     (d_we),
    .d_dw     (d_dw),
    .d_dr     (d_dr),
    .d_rdy    (d_rdy),
    .m_awaddr (m_awaddr),
    .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_wvalid (m_wvalid),
    .m_wready (m_wready),
    .m_bresp  (m_bresp),
    .m_bvalid (m_bvalid),
    .m_bready (m_bready),
    .m_araddr (m_araddr),
    .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rdata  (m_rdata),
    .m_rresp  (m_rresp),
    .m_rvalid (m_rvalid),
    .m_rready (m_rready),
    .err_clr  (err_clr),
    .err      (err),
    .err_adr  (err_adr)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Expected outputs for the current cycle.
  logic        chk_en = 1'b0;
  logic        e_rdy;
  logic [31:0] e_dr;
  logic        e_aw, e_w, e_b, e_ar, e_r;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [3:0]  e_wstrb;
  // Error register model.
  logic        m_err;
  logic [31:0] m_eadr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("d_rdy",     32'(d_rdy),     32'(e_rdy));
      check("d_dr",      d_dr,           e_dr);
      check("m_awvalid", 32'(m_awvalid), 32'(e_aw));
      check("m_wvalid",  32'(m_wvalid),  32'(e_w));
      check("m_bready",  32'(m_bready),  32'(e_b));
      check("m_arvalid", 32'(m_arvalid), 32'(e_ar));
      check("m_rready",  32'(m_rready),  32'(e_r));
      check("err",       32'(err),       32'(m_err));
      check("err_adr",   err_adr,        m_eadr);
      if (e_aw) check("m_awaddr", m_awaddr, e_addr);
      if (e_ar) check("m_araddr", m_araddr, e_addr);
      if (e_w) begin
        check("m_wdata", m_wdata, e_wdata);
        check("m_wstrb", 32'(m_wstrb), 32'(e_wstrb));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_exp(input logic aw, input logic w, input logic b, input logic ar, input logic r);
    e_aw = aw; e_w = w; e_b = b; e_ar = ar; e_r = r;
  endtask

  task automatic idle_exp();
    e_rdy = 1'b1;
    e_dr  = '0;
    bus_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic to_idle();
    cyc();
    idle_exp();
  endtask

  task automatic note_err(input logic [31:0] a);
    if (!m_err) m_eadr = a;
    m_err = 1'b1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    m_err   = 1'b0;
    m_eadr  = '0;
  endtask

  // Read with the slave taking ar_wait cycles for arready and r_wait cycles
  // for rvalid. Ends in the cycle where d_rdy returns with data.
  task automatic read_txn(input logic [31:0] a, input logic [31:0] data, input logic [1:0] resp,
                          input int unsigned ar_wait, input int unsigned r_wait, input bit from_done);
    d_adr = a; d_re = 1'b1; d_we = '0;
    if (!from_done) idle_exp();
    e_addr = a;
    cyc();
    d_re = 1'b0;
    for (int unsigned k = 0; k <= ar_wait; k++) begin
      m_arready = (k == ar_wait);
      e_rdy = 1'b0; e_dr = '0;
      bus_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    m_arready = 1'b0;
    for (int unsigned k = 0; k <= r_wait; k++) begin
      m_rvalid = (k == r_wait);
      m_rdata  = (k == r_wait) ? data : 32'h0BAD_0BAD;
      m_rresp  = resp;
      e_rdy = 1'b0; e_dr = '0;
      bus_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc();
    end
    m_rvalid = 1'b0;
    e_rdy = 1'b1; e_dr = data;
    bus_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (resp != 2'b00) note_err(a);
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [3:0] we, input logic [31:0] dw,
                           input int unsigned aw_wait, input int unsigned w_wait, input int unsigned b_wait,
                           input logic [1:0] resp, input bit also_re, input bit from_done);
    int unsigned n;
    d_adr = a; d_we = we; d_dw = dw; d_re = also_re;
    if (!from_done) idle_exp();
    e_addr = a; e_wstrb = we; e_wdata = dw;
    cyc();
    d_we = '0; d_re = 1'b0;
    n = (aw_wait > w_wait) ? aw_wait : w_wait;
    for (int unsigned k = 0; k <= n; k++) begin
      m_awready = (k == aw_wait);
      m_wready  = (k == w_wait);
      e_rdy = 1'b0; e_dr = '0;
      bus_exp(k <= aw_wait, k <= w_wait, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    m_awready = 1'b0; m_wready = 1'b0;
    for (int unsigned k = 0; k <= b_wait; k++) begin
      m_bvalid = (k == b_wait);
      m_bresp  = resp;
      e_rdy = 1'b0; e_dr = '0;
      bus_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
    end
    m_bvalid = 1'b0;
    e_rdy = 1'b1; e_dr = '0;
    bus_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (resp != 2'b00) note_err(a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    xreset = 1'b0; d_adr = '0; d_re = 1'b0; d_we = '0; d_dw = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0; err_clr = 1'b0;
    m_err = 1'b0; m_eadr = '0;
    e_addr = '0; e_wdata = '0; e_wstrb = '0;
    idle_exp();
    chk_en = 1'b1;

    // Requests presented during reset are ignored.
    d_adr = 32'h8000_0000; d_re = 1'b1;
    repeat (3) cyc();
    d_re = 1'b0;
    xreset = 1'b1;
    cyc();

    // Out-of-window accesses: mtime region, just above and below the window.
    d_adr = 32'hFFFF_8000; d_re = 1'b1;
    cyc(); cyc();
    d_re = 1'b0; d_adr = 32'h9000_0000; d_we = 4'hF; d_dw = 32'h1111_2222;
    cyc();
    d_we = '0; d_adr = 32'h7FFF_FFFC; d_re = 1'b1;
    cyc();
    d_re = 1'b0;
    cyc();

    // Minimum-latency read.
    read_txn(32'h8000_0010, 32'h1234_5678, 2'b00, 0, 0, 1'b0);
    check("rd_dr_lit", d_dr, 32'h1234_5678);
    to_idle();

    // Write with awready delayed 3 cycles, wready immediate.
    write_txn(32'h8000_0004, 4'b0011, 32'h0000_ABCD, 3, 0, 1, 2'b00, 1'b0, 1'b0);
    to_idle();

    // Write with wready later than awready.
    write_txn(32'h8000_0008, 4'b1100, 32'h1234_0000, 0, 2, 0, 2'b00, 1'b0, 1'b0);
    to_idle();

    // Back-to-back: read, write (with d_re also set) accepted in DONE, read
    // at the top of the window accepted in the next DONE.
    read_txn(32'h8000_0020, 32'hA5A5_0001, 2'b00, 1, 1, 1'b0);
    write_txn(32'h8000_0030, 4'hF, 32'hCAFE_F00D, 0, 0, 0, 2'b00, 1'b1, 1'b1);
    read_txn(32'h8FFF_FFFC, 32'h0F0F_F0F0, 2'b00, 0, 2, 1'b1);
    to_idle();

    // Read timeout: slave never answers.
    d_adr = 32'h8000_0010; d_re = 1'b1; e_addr = 32'h8000_0010;
    cyc();
    d_re = 1'b0;
    for (int unsigned k = 0; k < TO - 1; k++) begin
      e_rdy = 1'b0; e_dr = '0;
      bus_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    e_rdy = 1'b0; e_dr = '0;
    bus_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    e_rdy = 1'b1; e_dr = 32'hDEAD_BEEF;
    note_err(32'h8000_0010);
    check("to_dr_lit",   d_dr,     32'hDEAD_BEEF);
    check("to_err_lit",  32'(err), 32'd1);
    check("to_eadr_lit", err_adr,  32'h8000_0010);
    to_idle();

    // Error from bresp, first-error-wins on a later rresp error, clears.
    clear_err();
    check("clr_err_lit", 32'(err), 32'd0);
    write_txn(32'h8000_0040, 4'hF, 32'h0000_0001, 0, 0, 0, 2'b10, 1'b0, 1'b0);
    check("bresp_eadr_lit", err_adr, 32'h8000_0040);
    to_idle();
    read_txn(32'h8000_0050, 32'h55AA_55AA, 2'b10, 0, 0, 1'b0);
    check("rresp_dr_lit",   d_dr,    32'h55AA_55AA);
    check("first_eadr_lit", err_adr, 32'h8000_0040);
    to_idle();
    clear_err();

    // Reset asserted while waiting in RADDR.
    d_adr = 32'h8000_0060; d_re = 1'b1; e_addr = 32'h8000_0060;
    cyc();
    d_re = 1'b0;
    e_rdy = 1'b0; e_dr = '0;
    bus_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    xreset = 1'b0;
    idle_exp();
    m_err = 1'b0; m_eadr = '0;
    #1;
    check("rst_rdy_lit", 32'(d_rdy),     32'd1);
    check("rst_ar_lit",  32'(m_arvalid), 32'd0);
    cyc();
    xreset = 1'b1;
    cyc();

    // Normal operation after the aborted transaction.
    read_txn(32'h8000_0070, 32'h7777_0070, 2'b00, 0, 0, 1'b0);
    to_idle();
    cyc();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_dbus_axil.md
Name: rv_dbus_axil

Overview:
Data-side bus bridge that sits directly downstream of the rv32 core's data memory port (d_adr/d_re/d_we/d_dw/d_dr/d_rdy). It decodes each core access and converts those that fall in the external window into single AXI4-Lite master transactions, holding the core with d_rdy low until the transaction completes. Accesses outside the window, including the core-internal mtime/mtimecmp addresses, complete with zero latency and return 0 on d_dr, because the core ORs d_dr with its internal read data. Bus errors and timeouts are captured in a sticky error register.

Parameters:
EXT_BASE, 32'h8000_0000, window base; access is external when (d_adr & EXT_MASK) == EXT_BASE
EXT_MASK, 32'hF000_0000, window decode mask
TIMEOUT, 1024, maximum cycles from transaction issue to response before abort (>=4)

Ports:
clk  in  1  clock
xreset  in  1  asynchronous active-low reset
d_adr  in  32  core data address
d_re  in  1  core read enable
d_we  in  4  core byte write enables; nonzero means write
d_dw  in  32  core write data, already lane-aligned
d_dr  out  32  read data to core
d_rdy  out  1  data ready/stall to core
m_awaddr  out  32  AXI write address
m_awvalid  out  1  AXI
m_awready  in  1  AXI
m_wdata  out  32  AXI
m_wstrb  out  4  AXI, equals captured d_we
m_wvalid  out  1  AXI
m_wready  in  1  AXI
m_bresp  in  2  AXI
m_bvalid  in  1  AXI
m_bready  out  1  AXI
m_araddr  out  32  AXI read address
m_arvalid  out  1  AXI
m_arready  in  1  AXI
m_rdata  in  32  AXI
m_rresp  in  2  AXI
m_rvalid  in  1  AXI
m_rready  out  1  AXI
err_clr  in  1  clears err/err_adr
err  out  1  sticky error flag
err_adr  out  32  address of the first failing access

Behaviour:
- Reset (xreset=0, asynchronous): state=IDLE; d_rdy=1; d_dr=0; all m_*valid, m_bready, m_rready=0; err=0; err_adr=0; timeout counter=0.
- Core protocol: a request is accepted on a rising edge where d_rdy=1 and (d_re=1 or d_we!=0). The core advances on that edge. Data for a read is returned in the first later cycle in which d_rdy=1.
- Capture: on acceptance of an in-window request, latch address, d_dw, d_we and type. Writes take priority if d_re and d_we are both set. Out-of-window requests are not captured, d_rdy stays 1, and d_dr=0.
- States:
  - IDLE: d_rdy=1, d_dr=0. Accepted write goes to WADDR; accepted read goes to RADDR.
  - WADDR: m_awvalid and m_wvalid are asserted together. Each drops independently on its handshake and is tracked by aw_done/w_done flags. Go to WRESP when both are done, including both in the same cycle. d_rdy=0.
  - WRESP: m_bready=1. On m_bvalid go to DONE. A nonzero m_bresp sets the error.
  - RADDR: m_arvalid=1 until m_arready, then go to RDATA.
  - RDATA: m_rready=1. On m_rvalid, latch m_rdata and go to DONE. A nonzero m_rresp sets the error but data is still returned.
  - DONE: d_rdy=1. d_dr=latched rdata for a read, 0 for a write. A request present this cycle is accepted per the capture rule, going straight to WADDR or RADDR; otherwise go to IDLE.
- Valid signals are held stable until their handshake and never deasserted early, except on timeout.
- Minimum latency with always-ready slave: accept at edge N; d_rdy=0 in cycles N+1 and N+2; d_rdy=1 with data in N+3.
- Timeout: the counter clears on accept and increments every cycle in WADDR/WRESP/RADDR/RDATA. When it reaches TIMEOUT-1, drop all valids and readies, go to DONE with d_dr=32'hDEAD_BEEF (reads) or 0 (writes), and set the error.
- Error: err<=1. err_adr is loaded only if err was 0, so the first error wins. err_clr clears both; an error event in the same cycle as err_clr wins.
- m_awaddr/m_araddr carry the captured address unmodified. Byte lanes are passed through; there is no endian handling.
- Reset mid-transaction aborts immediately to reset values; no AXI completion is awaited.

Test Plan:
- Out-of-window read of 0xFFFF8000 with d_re=1 -> d_rdy stays 1, d_dr=0, no AXI valid asserted.
- Read of 0x8000_0010, slave arready=1 and rvalid=1 immediately with rdata=0x12345678 -> d_rdy low for exactly 2 cycles, then 1 with d_dr=0x12345678.
- Write of 0x8000_0004, d_we=4'b0011, d_dw=0x0000ABCD, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid after 4 cycles, m_wstrb=0011, then bready; d_rdy returns after bvalid, d_dr=0.
- Back-to-back read then write with the write presented during the DONE cycle -> write accepted in DONE, goes directly to WADDR, no IDLE cycle.
- Read with slave never responding (TIMEOUT=16) -> arvalid drops at count 15, d_dr=0xDEADBEEF, err=1, err_adr=0x8000_0010.
- Write returning bresp=2'b10, then err_clr pulse, then reset asserted during RADDR -> err set then cleared; reset immediately forces d_rdy=1 and arvalid=0.
